// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_queue_pkg                                             |
// | Purpose  : Shared types and constants for the ALU issue queue: physical    |
// |            register tag, uOP payload, dispatch metadata, queue entry and   |
// |            arbitration info, plus an entry-readiness helper.               |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_issue_queue_pkg;

  localparam int ALU_IQ_DEPTH = 8;
  localparam int PRF_W        = 6;

  typedef logic [PRF_W-1:0] PRFNum;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  aluOp;
    PRFNum       op0PAddr;
    PRFNum       op1PAddr;
    PRFNum       dstPAddr;
    logic [31:0] imm;
  } UOPBundle;

  // rdys[0] = prs1 ready, rdys[1] = prs2 ready
  typedef struct packed {
    UOPBundle   ops;
    logic [1:0] rdys;
  } ALU_Queue_Meta;

  typedef struct packed {
    logic       valid;
    UOPBundle   ops;
    logic [1:0] rdys;
  } ALU_IQ_Entry;

  typedef struct packed {
    logic                            valid;
    logic [$clog2(ALU_IQ_DEPTH)-1:0] idx;
  } Arbitration_Info;

  function automatic logic entry_ready(input logic valid, input logic [1:0] rdys);
    return valid & rdys[0] & rdys[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_wakeup_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iq_wakeup_match                                                 |
// | Purpose  : Compares one source physical register against all wakeup       |
// |            broadcast ports and flags a hit.                                |
// | Ports    : tag        - source register to match                          |
// |            wake_valid - per-port broadcast strobe                          |
// |            wake_tag   - per-port broadcast destination register            |
// |            hit        - some valid broadcast matches tag                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module iq_wakeup_match
  import alu_issue_queue_pkg::*;
#(
  parameter int WAKE_N = 4
) (
  input  PRFNum                   tag,
  input  logic [WAKE_N-1:0]       wake_valid,
  input  PRFNum [WAKE_N-1:0]      wake_tag,
  output logic                    hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WAKE_N; i++) begin
      if (wake_valid[i] && (wake_tag[i] == tag)) begin
        hit = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_queue                                                 |
// | Purpose  : Dual-write, dual-issue collapsing reservation station for the  |
// |            ALU cluster. Index 0 is the oldest entry; the two oldest ready  |
// |            entries are offered to ALU0/ALU1.                               |
// | Ports    : clk, rst (sync, active-low), flush                              |
// |            enq_wen_0/1, enq_din_0/1 - dispatch writes; full - < 2 free     |
// |            wake_valid/wake_tag      - wakeup broadcasts                     |
// |            issue_valid/ops/ready_0/1 - issue handshakes                     |
// |            count                    - occupancy                             |
// | Option   : ALU_IQ_WAKEUP_BYPASS_EN - select also sees same-cycle wakeups   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = ALU_IQ_DEPTH,
  parameter int WAKE_N = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                enq_wen_0,
  input  logic                enq_wen_1,
  input  ALU_Queue_Meta       enq_din_0,
  input  ALU_Queue_Meta       enq_din_1,
  output logic                full,
  input  logic [WAKE_N-1:0]   wake_valid,
  input  PRFNum [WAKE_N-1:0]  wake_tag,
  output logic                issue_valid_0,
  output UOPBundle            issue_ops_0,
  input  logic                issue_ready_0,
  output logic                issue_valid_1,
  output UOPBundle            issue_ops_1,
  input  logic                issue_ready_1,
  output logic [CNT_W-1:0]    count
);

  localparam int IDX_W = $clog2(DEPTH);

  ALU_IQ_Entry        entries_q [DEPTH];
  ALU_IQ_Entry        entries_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;

  logic [DEPTH-1:0]   hit_op0, hit_op1;
  ALU_Queue_Meta      enq_din [2];
  logic [1:0]         enq_hit [2];
  logic [DEPTH-1:0]   rdy_vec;

  logic               found_0, found_1;
  logic [IDX_W-1:0]   sel_0, sel_1;
  logic               fire_0, fire_1;
  logic               fired;
  logic               enq_ok;
  logic [CNT_W-1:0]   enq_n;
  logic [CNT_W-1:0]   wp;

  assign enq_din[0] = enq_din_0;
  assign enq_din[1] = enq_din_1;

  // Wakeup comparators for every resident operand
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    iq_wakeup_match #(.WAKE_N(WAKE_N)) u_match_op0 (
      .tag        (entries_q[i].ops.op0PAddr),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag),
      .hit        (hit_op0[i])
    );
    iq_wakeup_match #(.WAKE_N(WAKE_N)) u_match_op1 (
      .tag        (entries_q[i].ops.op1PAddr),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag),
      .hit        (hit_op1[i])
    );
  end

  // Incoming entries see same-cycle wakeups so no broadcast is lost at dispatch
  for (genvar p = 0; p < 2; p++) begin : g_enq
    iq_wakeup_match #(.WAKE_N(WAKE_N)) u_match_op0 (
      .tag        (enq_din[p].ops.op0PAddr),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag),
      .hit        (enq_hit[p][0])
    );
    iq_wakeup_match #(.WAKE_N(WAKE_N)) u_match_op1 (
      .tag        (enq_din[p].ops.op1PAddr),
      .wake_valid (wake_valid),
      .wake_tag   (wake_tag),
      .hit        (enq_hit[p][1])
    );
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
      rdy_vec[i] = entry_ready(entries_q[i].valid,
                               entries_q[i].rdys | {hit_op1[i], hit_op0[i]});
`else
      rdy_vec[i] = entry_ready(entries_q[i].valid, entries_q[i].rdys);
`endif
    end
  end

  // Oldest-first select of two ready slots
  always_comb begin
    found_0 = 1'b0;
    found_1 = 1'b0;
    sel_0   = '0;
    sel_1   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_vec[i]) begin
        if (!found_0) begin
          found_0 = 1'b1;
          sel_0   = IDX_W'(i);
        end else if (!found_1) begin
          found_1 = 1'b1;
          sel_1   = IDX_W'(i);
        end
      end
    end
  end

  assign issue_valid_0 = found_0 & ~flush;
  assign issue_valid_1 = found_1 & ~flush;
  assign issue_ops_0   = entries_q[sel_0].ops;
  assign issue_ops_1   = entries_q[sel_1].ops;
  assign fire_0        = issue_valid_0 & issue_ready_0;
  assign fire_1        = issue_valid_1 & issue_ready_1;
  assign enq_ok        = ~full_q & ~flush;

  // Collapse survivors to the bottom, then append new entries in order
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = '0;
    end
    wp    = '0;
    fired = 1'b0;
    enq_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fired = (fire_0 && (sel_0 == IDX_W'(i))) || (fire_1 && (sel_1 == IDX_W'(i)));
      if (entries_q[i].valid && !fired) begin
        entries_d[wp[IDX_W-1:0]].valid = 1'b1;
        entries_d[wp[IDX_W-1:0]].ops   = entries_q[i].ops;
        entries_d[wp[IDX_W-1:0]].rdys  = entries_q[i].rdys | {hit_op1[i], hit_op0[i]};
        wp = wp + CNT_W'(1);
      end
    end
    // A lone enq_wen_1 is illegal and ignored
    if (enq_ok && enq_wen_0) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 || enq_wen_1) && (wp < CNT_W'(DEPTH))) begin
          entries_d[wp[IDX_W-1:0]].valid = 1'b1;
          entries_d[wp[IDX_W-1:0]].ops   = enq_din[p].ops;
          entries_d[wp[IDX_W-1:0]].rdys  = enq_din[p].rdys | enq_hit[p];
          wp    = wp + CNT_W'(1);
          enq_n = enq_n + CNT_W'(1);
        end
      end
    end
    count_d = count_q - CNT_W'(fire_0) - CNT_W'(fire_1) + enq_n;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      count_d = '0;
    end
    // Full ignores same-cycle issues on purpose: keeps it a pure flop
    full_d = (count_d > CNT_W'(DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(enq_wen_1 && !enq_wen_0))
        else $error("alu_issue_queue: enq_wen_1 asserted without enq_wen_0");
      assert (!(enq_wen_0 && full_q && !flush))
        else $warning("alu_issue_queue: enqueue while full, write dropped");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_issue_queue                                              |
// | Purpose  : Directed bench for alu_issue_queue. Expected issues are queued  |
// |            by the stimulus and consumed by a negedge monitor; occupancy   |
// |            and handshake state are checked directly.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int WAKE_N = 4;
  localparam int CNT_W  = 4;
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, flush, enq_wen_0, enq_wen_1;
  logic               issue_ready_0, issue_ready_1;
  ALU_Queue_Meta      enq_din_0, enq_din_1;
  logic               full, issue_valid_0, issue_valid_1;
  logic [WAKE_N-1:0]  wake_valid;
  PRFNum [WAKE_N-1:0] wake_tag;
  UOPBundle           issue_ops_0, issue_ops_1;
  logic [CNT_W-1:0]   count;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [32:0]        exp_q [$];   // {port, pc}

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .WAKE_N(WAKE_N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_wen_0     (enq_wen_0),
    .enq_wen_1     (enq_wen_1),
    .enq_din_0     (enq_din_0),
    .enq_din_1     (enq_din_1),
    .full          (full),
    .wake_valid    (wake_valid),
    .wake_tag      (wake_tag),
    .issue_valid_0 (issue_valid_0),
    .issue_ops_0   (issue_ops_0),
    .issue_ready_0 (issue_ready_0),
    .issue_valid_1 (issue_valid_1),
    .issue_ops_1   (issue_ops_1),
    .issue_ready_1 (issue_ready_1),
    .count         (count)
  );

  function automatic ALU_Queue_Meta mk(input logic [31:0] pc, input logic [1:0] rdys,
                                       input PRFNum op0, input PRFNum op1);
    ALU_Queue_Meta m;
    m               = '0;
    m.ops.pc        = pc;
    m.ops.op0PAddr  = op0;
    m.ops.op1PAddr  = op1;
    m.rdys          = rdys;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic port, input logic [31:0] pc);
    logic [32:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL issue_unexpected: got port%0d pc=%0h, expected no issue", port, pc);
    end else begin
      e = exp_q.pop_front();
      if (e !== {port, pc}) begin
        n_fail++;
        $display("FAIL issue_order: got port%0d pc=%0h, expected port%0d pc=%0h",
                 port, pc, e[32], e[31:0]);
      end
    end
  endtask

  // Monitor: every handshake that will fire at the next edge must match the queue head
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (issue_valid_0 && issue_ready_0) sb_check(1'b0, issue_ops_0.pc);
      if (issue_valid_1 && issue_ready_1) sb_check(1'b1, issue_ops_1.pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic w0, input logic w1, input ALU_Queue_Meta d0,
                     input ALU_Queue_Meta d1);
    enq_wen_0 = w0;
    enq_wen_1 = w1;
    enq_din_0 = d0;
    enq_din_1 = d1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    enq(1'b0, 1'b0, '0, '0);
    issue_ready_0 = 1'b0; issue_ready_1 = 1'b0;
    wake_valid = '0; wake_tag = '0;
    step(); step();
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_iv0", 32'(issue_valid_0), 0);
    chk("rst_iv1", 32'(issue_valid_1), 0);
    step();
    rst = 1'b1;

    // Two ready ops issue together one cycle after enqueue
    issue_ready_0 = 1'b1; issue_ready_1 = 1'b1;
    enq(1'b1, 1'b1, mk(32'h100, 2'b11, 6'd0, 6'd0), mk(32'h104, 2'b11, 6'd0, 6'd0));
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b1, 32'h104});
    step();
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("pair_count_2", 32'(count), 2);
    step();
    @(negedge clk);
    chk("pair_count_0", 32'(count), 0);

    // Resident wakeup on port 2
    enq(1'b1, 1'b0, mk(32'h200, 2'b10, 6'd17, 6'd0), '0);
    step();
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wait_iv0", 32'(issue_valid_0), 0);
    step();
    wake_valid = 4'b0100;
    wake_tag[2] = 6'd17;
    exp_q.push_back({1'b0, 32'h200});
    @(negedge clk);
    chk("wake_cycle_iv0", 32'(issue_valid_0), 32'(BYP));
    step();
    wake_valid = '0;
    step();
    @(negedge clk);
    chk("wake_count_0", 32'(count), 0);
    chk("wake_drained", 32'(exp_q.size()), 0);

    // Wakeup coinciding with dispatch sets prs2 on write
    enq(1'b1, 1'b0, mk(32'h300, 2'b01, 6'd0, 6'd5), '0);
    wake_valid = 4'b0001;
    wake_tag[0] = 6'd5;
    exp_q.push_back({1'b0, 32'h300});
    step();
    enq(1'b0, 1'b0, '0, '0);
    wake_valid = '0;
    @(negedge clk);
    chk("enq_bypass_iv0", 32'(issue_valid_0), 1);
    step();
    @(negedge clk);
    chk("enq_bypass_count", 32'(count), 0);

    // Port1 fires while port0 stalls; order kept after collapse
    issue_ready_0 = 1'b0; issue_ready_1 = 1'b0;
    enq(1'b1, 1'b1, mk(32'h400, 2'b11, 6'd0, 6'd0), mk(32'h404, 2'b11, 6'd0, 6'd0));
    step();
    enq(1'b1, 1'b0, mk(32'h408, 2'b11, 6'd0, 6'd0), '0);
    step();
    enq(1'b0, 1'b0, '0, '0);
    issue_ready_1 = 1'b1;
    exp_q.push_back({1'b1, 32'h404});
    @(negedge clk);
    chk("abc_count_3", 32'(count), 3);
    step();
    issue_ready_1 = 1'b0;
    @(negedge clk);
    chk("collapse_port0_A", issue_ops_0.pc, 32'h400);
    chk("collapse_port1_C", issue_ops_1.pc, 32'h408);
    chk("collapse_count_2", 32'(count), 2);
    step();
    issue_ready_0 = 1'b1; issue_ready_1 = 1'b1;
    exp_q.push_back({1'b0, 32'h400});
    exp_q.push_back({1'b1, 32'h408});
    step();
    issue_ready_0 = 1'b0; issue_ready_1 = 1'b0;
    @(negedge clk);
    chk("abc_count_0", 32'(count), 0);
    chk("abc_drained", 32'(exp_q.size()), 0);

    // Fill to 7, then a write while full is dropped
    for (int k = 0; k < 3; k++) begin
      enq(1'b1, 1'b1, mk(32'h500 + 32'(8 * k), 2'b11, 6'd0, 6'd0),
                      mk(32'h504 + 32'(8 * k), 2'b11, 6'd0, 6'd0));
      step();
    end
    enq(1'b1, 1'b0, mk(32'h518, 2'b11, 6'd0, 6'd0), '0);
    @(negedge clk);
    chk("fill_count_6", 32'(count), 6);
    chk("fill_full_6", 32'(full), 0);
    step();
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("fill_count_7", 32'(count), 7);
    chk("fill_full_7", 32'(full), 1);
    step();
    enq(1'b1, 1'b1, mk(32'h520, 2'b11, 6'd0, 6'd0), mk(32'h524, 2'b11, 6'd0, 6'd0));
    step();
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("drop_count_7", 32'(count), 7);
    chk("drop_full", 32'(full), 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_full_count", 32'(count), 0);
    chk("flush_full_full", 32'(full), 0);

    // Flush with 5 entries and a simultaneous enqueue
    step();
    enq(1'b1, 1'b1, mk(32'h600, 2'b11, 6'd0, 6'd0), mk(32'h604, 2'b11, 6'd0, 6'd0));
    step();
    enq(1'b1, 1'b1, mk(32'h608, 2'b11, 6'd0, 6'd0), mk(32'h60c, 2'b11, 6'd0, 6'd0));
    step();
    enq(1'b1, 1'b0, mk(32'h610, 2'b11, 6'd0, 6'd0), '0);
    step();
    enq(1'b1, 1'b1, mk(32'h614, 2'b11, 6'd0, 6'd0), mk(32'h618, 2'b11, 6'd0, 6'd0));
    flush = 1'b1;
    issue_ready_0 = 1'b1; issue_ready_1 = 1'b1;
    @(negedge clk);
    chk("flush5_pre_count", 32'(count), 5);
    chk("flush5_iv0_sup", 32'(issue_valid_0), 0);
    chk("flush5_iv1_sup", 32'(issue_valid_1), 0);
    step();
    flush = 1'b0;
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("flush5_count", 32'(count), 0);
    chk("flush5_full", 32'(full), 0);
    chk("flush5_iv0", 32'(issue_valid_0), 0);
    chk("flush5_iv1", 32'(issue_valid_1), 0);
    step();
    issue_ready_0 = 1'b0; issue_ready_1 = 1'b0;

    // Reset mid-operation beats a same-cycle enqueue
    enq(1'b1, 1'b1, mk(32'h700, 2'b00, 6'd1, 6'd2), mk(32'h704, 2'b00, 6'd3, 6'd4));
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    enq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_full", 32'(full), 0);

    step();
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
